// File: rtl/axis_load_sequencer.sv
// axis_load_sequencer
// Sequences PS-to-PL waveform loads through a one-hot channel selector.
// A load command (channel, beat count) drives a registered one-hot select,
// waits one cycle for the selector to settle, then opens the AXI-Stream
// handshake until the requested number of beats has been counted. Data does
// not pass through this block; only valid/ready are gated here.
//
// Ports
//   i_clk, i_rstn              clock, async active-low reset
//   i_cmd_valid/o_cmd_ready    command handshake
//   i_cmd_channel, i_cmd_beats command payload (beats == 0 is illegal)
//   i_abort                    terminate the active load (SELECT/STREAM only)
//   o_channel_select           registered one-hot select, 0 when idle
//   i_s_axis_tvalid/o_s_axis_tready   PS-side handshake
//   o_m_axis_tvalid/i_m_axis_tready   selector-side handshake
//   o_busy, o_done, o_done_channel, o_cmd_err   status
//   o_loaded_mask, i_clear_loaded     sticky per-channel completion bits
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SELECT | select registered, stream gated for one settle cycle
// STREAM | handshake passes through, beats counted down
// DONE   | one-cycle completion: done pulse, mask bit set, select cleared
module axis_load_sequencer #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = 4,
  parameter int LEN_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [CH_W-1:0]   i_cmd_channel,
  input  logic [LEN_W-1:0]  i_cmd_beats,
  input  logic              i_abort,
  output logic [NUM_CH-1:0] o_channel_select,
  input  logic              i_s_axis_tvalid,
  output logic              o_s_axis_tready,
  output logic              o_m_axis_tvalid,
  input  logic              i_m_axis_tready,
  output logic              o_busy,
  output logic              o_done,
  output logic [CH_W-1:0]   o_done_channel,
  output logic              o_cmd_err,
  output logic [NUM_CH-1:0] o_loaded_mask,
  input  logic              i_clear_loaded
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [NUM_CH-1:0] ONE_HOT_LSB = {{(NUM_CH-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [CH_W-1:0]     r_ch;
  logic [LEN_W-1:0]    r_remaining;
  logic [NUM_CH-1:0]   r_channel_select;
  logic [NUM_CH-1:0]   r_loaded_mask;
  logic [CH_W-1:0]     r_done_channel;
  logic                r_done;
  logic                r_cmd_err;

  logic                w_cmd_hs;
  logic                w_cmd_bad;
  logic                w_beat;
  logic                w_last_beat;
  logic [NUM_CH-1:0]   w_ch_onehot;

  assign w_cmd_hs    = (r_state == IDLE) && i_cmd_valid;
  assign w_cmd_bad   = (i_cmd_beats == '0) || (32'(i_cmd_channel) >= NUM_CH);
  assign w_beat      = (r_state == STREAM) && i_s_axis_tvalid && i_m_axis_tready;
  assign w_last_beat = w_beat && (r_remaining == LEN_W'(1));
  assign w_ch_onehot = ONE_HOT_LSB << r_ch;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    o_cmd_ready     = 1'b0;
    o_busy          = 1'b1;
    o_m_axis_tvalid = 1'b0;
    o_s_axis_tready = 1'b0;
    case (r_state)
      IDLE: begin
        o_cmd_ready = 1'b1;
        o_busy      = 1'b0;
        if (w_cmd_hs && !w_cmd_bad) w_next = SELECT;
      end
      SELECT: begin
        w_next = i_abort ? IDLE : STREAM;
      end
      STREAM: begin
        o_m_axis_tvalid = i_s_axis_tvalid;
        o_s_axis_tready = i_m_axis_tready;
        // abort wins over a coinciding last beat: no credit, no done
        if (i_abort)          w_next = IDLE;
        else if (w_last_beat) w_next = DONE;
      end
      DONE: begin
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_ch             <= '0;
      r_remaining      <= '0;
      r_channel_select <= '0;
      r_loaded_mask    <= '0;
      r_done_channel   <= '0;
      r_done           <= 1'b0;
      r_cmd_err        <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_cmd_err <= 1'b0;

      // DONE sets its bit after clear is applied, so the new bit survives
      if (r_state == DONE) begin
        if (i_clear_loaded) r_loaded_mask <= w_ch_onehot;
        else                r_loaded_mask <= r_loaded_mask | w_ch_onehot;
      end else if (i_clear_loaded) begin
        r_loaded_mask <= '0;
      end

      case (r_state)
        IDLE: begin
          if (w_cmd_hs) begin
            if (w_cmd_bad) begin
              r_cmd_err <= 1'b1;
            end else begin
              r_ch             <= i_cmd_channel;
              r_remaining      <= i_cmd_beats;
              r_channel_select <= ONE_HOT_LSB << i_cmd_channel;
            end
          end
        end
        SELECT: begin
          if (i_abort) r_channel_select <= '0;
        end
        STREAM: begin
          if (i_abort) begin
            r_channel_select <= '0;
          end else if (w_beat) begin
            r_remaining <= r_remaining - LEN_W'(1);
            // done is registered so it is high for exactly the DONE cycle
            if (w_last_beat) begin
              r_done         <= 1'b1;
              r_done_channel <= r_ch;
            end
          end
        end
        DONE: begin
          r_channel_select <= '0;
        end
        default: ;
      endcase
    end
  end

  assign o_channel_select = r_channel_select;
  assign o_loaded_mask    = r_loaded_mask;
  assign o_done_channel   = r_done_channel;
  assign o_done           = r_done;
  assign o_cmd_err        = r_cmd_err;

endmodule

// File: tb/tb_axis_load_sequencer.sv
module tb_axis_load_sequencer;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_channel;
  logic [15:0] cmd_beats;
  logic        abort;
  logic [15:0] channel_select;
  logic        s_tvalid;
  logic        s_tready;
  logic        m_tvalid;
  logic        m_tready;
  logic        busy;
  logic        done;
  logic [3:0]  done_channel;
  logic        cmd_err;
  logic [15:0] loaded_mask;
  logic        clear_loaded;

  int tests_run;
  int tests_failed;

  axis_load_sequencer #(.NUM_CH(16), .CH_W(4), .LEN_W(16)) dut (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_cmd_valid      (cmd_valid),
    .o_cmd_ready      (cmd_ready),
    .i_cmd_channel    (cmd_channel),
    .i_cmd_beats      (cmd_beats),
    .i_abort          (abort),
    .o_channel_select (channel_select),
    .i_s_axis_tvalid  (s_tvalid),
    .o_s_axis_tready  (s_tready),
    .o_m_axis_tvalid  (m_tvalid),
    .i_m_axis_tready  (m_tready),
    .o_busy           (busy),
    .o_done           (done),
    .o_done_channel   (done_channel),
    .o_cmd_err        (cmd_err),
    .o_loaded_mask    (loaded_mask),
    .i_clear_loaded   (clear_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rstn = 1'b0; cmd_valid = 0; cmd_channel = 0; cmd_beats = 0; abort = 0;
    s_tvalid = 1; m_tready = 1; clear_loaded = 0;
    #3;
    tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b exp 0", busy); end
    tests_run++; if (channel_select !== 16'h0) begin tests_failed++; $display("FAIL reset_sel got %h exp 0000", channel_select); end
    tests_run++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin tests_failed++; $display("FAIL reset_gate got m_tvalid=%b s_tready=%b exp 0 0", m_tvalid, s_tready); end
    tests_run++; if (done !== 1'b0 || cmd_err !== 1'b0) begin tests_failed++; $display("FAIL reset_pulses got done=%b cmd_err=%b exp 0 0", done, cmd_err); end
    tests_run++; if (loaded_mask !== 16'h0 || done_channel !== 4'h0) begin tests_failed++; $display("FAIL reset_regs got mask=%h done_ch=%0d exp 0 0", loaded_mask, done_channel); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_basic();
    logic [7:0]  hs_tab;
    logic [7:0]  done_tab;
    logic [15:0] exp_sel;
    hs_tab   = 8'b0011_1100;
    done_tab = 8'b0100_0000;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd5; cmd_beats = 16'd4; s_tvalid = 1; m_tready = 1;
      #1;
      if (k == 0) begin
        tests_run++; if (cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_cmd_ready got %b exp 1", cmd_ready); end
      end
      exp_sel = (k >= 1 && k <= 6) ? 16'h0020 : 16'h0000;
      tests_run++; if (channel_select !== exp_sel) begin tests_failed++; $display("FAIL basic_sel k=%0d got %h exp %h", k, channel_select, exp_sel); end
      tests_run++; if (s_tready !== hs_tab[k] || m_tvalid !== hs_tab[k]) begin tests_failed++; $display("FAIL basic_hs k=%0d got s_tready=%b m_tvalid=%b exp %b", k, s_tready, m_tvalid, hs_tab[k]); end
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL basic_done k=%0d got %b exp %b", k, done, done_tab[k]); end
      if (k == 6) begin
        tests_run++; if (done_channel !== 4'd5) begin tests_failed++; $display("FAIL basic_done_ch got %0d exp 5", done_channel); end
      end
    end
    tests_run++; if (loaded_mask !== 16'h0020) begin tests_failed++; $display("FAIL basic_mask got %h exp 0020", loaded_mask); end
    tests_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_idle got busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready); end
  endtask

  task automatic test_stalls();
    logic [10:0] hs_tab;
    logic [10:0] done_tab;
    logic [15:0] exp_sel;
    int          beats;
    hs_tab   = 11'b001_0100_0100;
    done_tab = 11'b010_0000_0000;
    beats    = 0;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd15; cmd_beats = 16'd3;
      s_tvalid = (k % 2 == 0); m_tready = !(k == 4 || k == 5);
      #1;
      if (s_tvalid && s_tready) beats++;
      exp_sel = (k >= 1 && k <= 9) ? 16'h8000 : 16'h0000;
      tests_run++; if (channel_select !== exp_sel) begin tests_failed++; $display("FAIL stall_sel k=%0d got %h exp %h", k, channel_select, exp_sel); end
      tests_run++; if ((s_tvalid && s_tready) !== hs_tab[k] || (m_tvalid && m_tready) !== hs_tab[k]) begin tests_failed++; $display("FAIL stall_hs k=%0d got s_tready=%b m_tvalid=%b exp hs=%b", k, s_tready, m_tvalid, hs_tab[k]); end
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL stall_done k=%0d got %b exp %b", k, done, done_tab[k]); end
    end
    tests_run++; if (beats != 3) begin tests_failed++; $display("FAIL stall_beats got %0d exp 3", beats); end
    tests_run++; if (loaded_mask !== 16'h8020) begin tests_failed++; $display("FAIL stall_mask got %h exp 8020", loaded_mask); end
    tests_run++; if (done_channel !== 4'd15) begin tests_failed++; $display("FAIL stall_done_ch got %0d exp 15", done_channel); end
  endtask

  task automatic test_illegal();
    logic [2:0] err_tab;
    err_tab = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd1; cmd_beats = 16'd0; s_tvalid = 1; m_tready = 1;
      #1;
      tests_run++; if (cmd_err !== err_tab[k]) begin tests_failed++; $display("FAIL illegal_err k=%0d got %b exp %b", k, cmd_err, err_tab[k]); end
      tests_run++; if (busy !== 1'b0 || channel_select !== 16'h0) begin tests_failed++; $display("FAIL illegal_idle k=%0d got busy=%b sel=%h exp 0 0000", k, busy, channel_select); end
      tests_run++; if (s_tready !== 1'b0) begin tests_failed++; $display("FAIL illegal_gate k=%0d got s_tready=%b exp 0", k, s_tready); end
    end
    tests_run++; if (loaded_mask !== 16'h8020) begin tests_failed++; $display("FAIL illegal_mask got %h exp 8020", loaded_mask); end
  endtask

  task automatic test_abort();
    logic [10:0] hs_tab;
    logic [10:0] done_tab;
    logic [15:0] exp_sel;
    hs_tab   = 11'b001_0011_1100;
    done_tab = 11'b010_0000_0000;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      cmd_valid   = (k == 0) || (k == 6);
      cmd_channel = (k < 6) ? 4'd2 : 4'd3;
      cmd_beats   = (k < 6) ? 16'd8 : 16'd1;
      abort = (k == 5); s_tvalid = 1; m_tready = 1;
      #1;
      if (k >= 1 && k <= 5)      exp_sel = 16'h0004;
      else if (k >= 7 && k <= 9) exp_sel = 16'h0008;
      else                       exp_sel = 16'h0000;
      tests_run++; if (channel_select !== exp_sel) begin tests_failed++; $display("FAIL abort_sel k=%0d got %h exp %h", k, channel_select, exp_sel); end
      tests_run++; if (s_tready !== hs_tab[k]) begin tests_failed++; $display("FAIL abort_hs k=%0d got s_tready=%b exp %b", k, s_tready, hs_tab[k]); end
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL abort_done k=%0d got %b exp %b", k, done, done_tab[k]); end
      if (k == 6) begin
        tests_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL abort_idle got busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready); end
        tests_run++; if (done_channel !== 4'd15 || loaded_mask !== 16'h8020) begin tests_failed++; $display("FAIL abort_hold got done_ch=%0d mask=%h exp 15 8020", done_channel, loaded_mask); end
      end
      if (k == 9) begin
        tests_run++; if (done_channel !== 4'd3) begin tests_failed++; $display("FAIL abort_next_ch got %0d exp 3", done_channel); end
      end
    end
    tests_run++; if (loaded_mask !== 16'h8028) begin tests_failed++; $display("FAIL abort_mask got %h exp 8028", loaded_mask); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  done_tab;
    logic [8:0]  rdy_tab;
    logic [15:0] exp_sel;
    @(negedge clk);
    cmd_valid = 0; clear_loaded = 1;
    @(negedge clk);
    clear_loaded = 0;
    #1;
    tests_run++; if (loaded_mask !== 16'h0) begin tests_failed++; $display("FAIL clear_mask got %h exp 0000", loaded_mask); end
    done_tab = 9'b0_1000_1000;
    rdy_tab  = 9'b1_0001_0001;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0) || (k == 4); cmd_channel = (k < 4) ? 4'd0 : 4'd1; cmd_beats = 16'd1;
      s_tvalid = 1; m_tready = 1;
      #1;
      if (k >= 1 && k <= 3)      exp_sel = 16'h0001;
      else if (k >= 5 && k <= 7) exp_sel = 16'h0002;
      else                       exp_sel = 16'h0000;
      tests_run++; if (channel_select !== exp_sel) begin tests_failed++; $display("FAIL b2b_sel k=%0d got %h exp %h", k, channel_select, exp_sel); end
      tests_run++; if (cmd_ready !== rdy_tab[k]) begin tests_failed++; $display("FAIL b2b_ready k=%0d got %b exp %b", k, cmd_ready, rdy_tab[k]); end
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL b2b_done k=%0d got %b exp %b", k, done, done_tab[k]); end
    end
    tests_run++; if (loaded_mask !== 16'h0003) begin tests_failed++; $display("FAIL b2b_mask got %h exp 0003", loaded_mask); end
  endtask

  task automatic test_clear_collision();
    logic [5:0] done_tab;
    done_tab = 6'b01_0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd7; cmd_beats = 16'd2; s_tvalid = 1; m_tready = 1;
      clear_loaded = (k == 4);
      #1;
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL coll_done k=%0d got %b exp %b", k, done, done_tab[k]); end
      if (k == 4) begin
        tests_run++; if (loaded_mask !== 16'h0003) begin tests_failed++; $display("FAIL coll_pre_mask got %h exp 0003", loaded_mask); end
      end
    end
    clear_loaded = 0;
    tests_run++; if (loaded_mask !== 16'h0080) begin tests_failed++; $display("FAIL coll_mask got %h exp 0080", loaded_mask); end
    tests_run++; if (done_channel !== 4'd7) begin tests_failed++; $display("FAIL coll_done_ch got %0d exp 7", done_channel); end
  endtask

  task automatic test_async_reset();
    logic [5:0] done_tab;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd9; cmd_beats = 16'd10; s_tvalid = 1; m_tready = 1;
    end
    #1;
    tests_run++; if (channel_select !== 16'h0200 || s_tready !== 1'b1) begin tests_failed++; $display("FAIL areset_pre got sel=%h s_tready=%b exp 0200 1", channel_select, s_tready); end
    @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    tests_run++; if (channel_select !== 16'h0 || loaded_mask !== 16'h0) begin tests_failed++; $display("FAIL areset_regs got sel=%h mask=%h exp 0000 0000", channel_select, loaded_mask); end
    tests_run++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL areset_state got busy=%b cmd_ready=%b exp 0 1", busy, cmd_ready); end
    tests_run++; if (m_tvalid !== 1'b0 || s_tready !== 1'b0) begin tests_failed++; $display("FAIL areset_gate got m_tvalid=%b s_tready=%b exp 0 0", m_tvalid, s_tready); end
    tests_run++; if (done_channel !== 4'd0 || done !== 1'b0 || cmd_err !== 1'b0) begin tests_failed++; $display("FAIL areset_status got done_ch=%0d done=%b err=%b exp 0 0 0", done_channel, done, cmd_err); end
    @(negedge clk);
    rstn = 1'b1;
    done_tab = 6'b01_0000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      cmd_valid = (k == 0); cmd_channel = 4'd4; cmd_beats = 16'd2; s_tvalid = 1; m_tready = 1;
      #1;
      tests_run++; if (done !== done_tab[k]) begin tests_failed++; $display("FAIL post_done k=%0d got %b exp %b", k, done, done_tab[k]); end
    end
    tests_run++; if (loaded_mask !== 16'h0010 || done_channel !== 4'd4) begin tests_failed++; $display("FAIL post_mask got mask=%h done_ch=%0d exp 0010 4", loaded_mask, done_channel); end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic();
    test_stalls();
    test_illegal();
    test_abort();
    test_back_to_back();
    test_clear_collision();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
